// File: rtl/spi_cmd_parser.sv
// SPI command parser: turns a byte stream into framebuffer row writes and a brightness register.
// Optional trailing XOR checksum per frame is compiled in with `define SPI_CMD_CHECKSUM_EN.
module spi_cmd_parser #(
  parameter int ROW_BYTES  = 192,
  parameter int ROW_ADDR_W = 5,
  parameter int COL_W      = 8
) (
  input  logic                        clk,
  input  logic                        rstb,
  input  logic                        ss,
  input  logic                        done,
  input  logic [7:0]                  rdata,
  output logic                        wr_en,
  output logic [ROW_ADDR_W+COL_W-1:0] wr_addr,
  output logic [7:0]                  wr_data,
  output logic [7:0]                  brightness,
  output logic                        frame_err,
  output logic                        busy
);

  localparam logic [7:0] CMD_ROW    = 8'h52;
  localparam logic [7:0] CMD_BRIGHT = 8'h42;
  localparam logic [7:0] CMD_NOP    = 8'h00;
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(ROW_BYTES - 1);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    ROW_ADDR = 3'd1,
    ROW_DATA = 3'd2,
    BRIGHT   = 3'd3,
    DROP     = 3'd4
`ifdef SPI_CMD_CHECKSUM_EN
    , CKSUM  = 3'd5
`endif
  } state_t;

`ifdef SPI_CMD_CHECKSUM_EN
  localparam state_t FRAME_END = CKSUM;
`else
  localparam state_t FRAME_END = IDLE;
`endif

  // [1:0] are the synchronizer flops, [2] holds the previous synchronized value
  logic [2:0] ss_sync, dn_sync;
  logic       ss_rise, byte_ev;

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      ss_sync <= 3'b111;
      dn_sync <= 3'b000;
    end else begin
      ss_sync <= {ss_sync[1:0], ss};
      dn_sync <= {dn_sync[1:0], done};
    end
  end

  assign ss_rise = ss_sync[1] & ~ss_sync[2];
  assign byte_ev = dn_sync[1] & ~dn_sync[2];

  logic [7:0] byte_q;
  logic       byte_vld;

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      byte_q   <= 8'h00;
      byte_vld <= 1'b0;
    end else begin
      byte_vld <= byte_ev;
      if (byte_ev) byte_q <= rdata;
    end
  end

  state_t                        state_q, state_d;
  logic [ROW_ADDR_W-1:0]         row_q, row_d;
  logic [COL_W-1:0]              col_q, col_d;
  logic [7:0]                    bright_q, bright_d;
  logic                          wr_en_d;
  logic [ROW_ADDR_W+COL_W-1:0]   wr_addr_d;
  logic [7:0]                    wr_data_d;
  logic                          err_d, err_q;
  logic                          ss_pend_q, ss_pend_d;
`ifdef SPI_CMD_CHECKSUM_EN
  logic [7:0]                    xor_q, xor_d, shadow_q, shadow_d;
`endif

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state_q   <= IDLE;
      row_q     <= '0;
      col_q     <= '0;
      bright_q  <= 8'hFF;
      wr_en     <= 1'b0;
      wr_addr   <= '0;
      wr_data   <= 8'h00;
      err_q     <= 1'b0;
      ss_pend_q <= 1'b0;
`ifdef SPI_CMD_CHECKSUM_EN
      xor_q     <= 8'h00;
      shadow_q  <= 8'hFF;
`endif
    end else begin
      state_q   <= state_d;
      row_q     <= row_d;
      col_q     <= col_d;
      bright_q  <= bright_d;
      wr_en     <= wr_en_d;
      wr_addr   <= wr_addr_d;
      wr_data   <= wr_data_d;
      err_q     <= err_d;
      ss_pend_q <= ss_pend_d;
`ifdef SPI_CMD_CHECKSUM_EN
      xor_q     <= xor_d;
      shadow_q  <= shadow_d;
`endif
    end
  end

  // A pending ss edge waits while a byte is in flight so the byte is decoded first.
  always_comb begin
    state_d   = state_q;
    row_d     = row_q;
    col_d     = col_q;
    bright_d  = bright_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr;
    wr_data_d = wr_data;
    err_d     = 1'b0;
    ss_pend_d = ss_pend_q | ss_rise;
`ifdef SPI_CMD_CHECKSUM_EN
    xor_d     = xor_q;
    shadow_d  = shadow_q;
`endif
    if (byte_vld) begin
`ifdef SPI_CMD_CHECKSUM_EN
      xor_d = xor_q ^ byte_q;
`endif
      case (state_q)
        IDLE: begin
`ifdef SPI_CMD_CHECKSUM_EN
          xor_d    = byte_q;
          shadow_d = bright_q;
`endif
          if (byte_q == CMD_ROW)         state_d = ROW_ADDR;
          else if (byte_q == CMD_BRIGHT) state_d = BRIGHT;
          else if (byte_q != CMD_NOP) begin
            err_d   = 1'b1;
            state_d = DROP;
          end
        end
        ROW_ADDR: begin
          if ((byte_q >> ROW_ADDR_W) != 8'h00) begin
            err_d   = 1'b1;
            state_d = DROP;
          end else begin
            row_d   = byte_q[ROW_ADDR_W-1:0];
            col_d   = '0;
            state_d = ROW_DATA;
          end
        end
        ROW_DATA: begin
          wr_en_d   = 1'b1;
          wr_addr_d = {row_q, col_q};
          wr_data_d = byte_q;
          if (col_q == COL_LAST) state_d = FRAME_END;
          else                   col_d   = col_q + 1'b1;
        end
        BRIGHT: begin
`ifdef SPI_CMD_CHECKSUM_EN
          shadow_d = byte_q;
`else
          bright_d = byte_q;
`endif
          state_d = FRAME_END;
        end
`ifdef SPI_CMD_CHECKSUM_EN
        CKSUM: begin
          if (byte_q == xor_q) bright_d = shadow_q;
          else                 err_d    = 1'b1;
          state_d = IDLE;
        end
`endif
        DROP:    state_d = DROP;
        default: state_d = IDLE;
      endcase
    end else if (ss_pend_q) begin
      ss_pend_d = ss_rise;
      if (state_q == DROP) begin
        state_d = IDLE;
      end else if (state_q != IDLE) begin
        err_d   = 1'b1;
        state_d = IDLE;
      end
    end
  end

  assign brightness = bright_q;
  assign frame_err  = err_q;
  assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_spi_cmd_parser.sv
// Directed bench for spi_cmd_parser with a frame-level reference model and a per-cycle write checker.
module tb_spi_cmd_parser;

  localparam int AW = 13;

  logic          clk = 1'b0;
  logic          rstb, ss, done;
  logic [7:0]    rdata;
  logic          wr_en, frame_err, busy;
  logic [AW-1:0] wr_addr;
  logic [7:0]    wr_data, brightness;

  spi_cmd_parser dut (
    .clk(clk), .rstb(rstb), .ss(ss), .done(done), .rdata(rdata),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .brightness(brightness), .frame_err(frame_err), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  // ---------------- reference model (frame level) ----------------
  typedef struct { logic [AW-1:0] a; logic [7:0] d; } wr_t;
  wr_t exp_q[$];

  localparam int M_IDLE = 0, M_RA = 1, M_RD = 2, M_BR = 3, M_CK = 4, M_DROP = 5;
  int         mode = M_IDLE;
  int         m_row, m_col;
  int         exp_err = 0;
  logic [7:0] exp_bright = 8'hFF;
  logic [7:0] m_x, m_shadow;

  task automatic mdl_byte(input logic [7:0] b);
    logic [7:0] x_prev;
    x_prev = m_x;
    m_x    = (mode == M_IDLE) ? b : (m_x ^ b);
    case (mode)
      M_IDLE: begin
        m_shadow = exp_bright;
        if (b == 8'h52)      mode = M_RA;
        else if (b == 8'h42) mode = M_BR;
        else if (b != 8'h00) begin exp_err++; mode = M_DROP; end
      end
      M_RA: begin
        if (b >= 8'd32) begin exp_err++; mode = M_DROP; end
        else begin m_row = int'(b); m_col = 0; mode = M_RD; end
      end
      M_RD: begin
        exp_q.push_back('{a: AW'(m_row * 256 + m_col), d: b});
        if (m_col == 191) begin
`ifdef SPI_CMD_CHECKSUM_EN
          mode = M_CK;
`else
          mode = M_IDLE;
`endif
        end else m_col++;
      end
      M_BR: begin
`ifdef SPI_CMD_CHECKSUM_EN
        m_shadow = b; mode = M_CK;
`else
        exp_bright = b; mode = M_IDLE;
`endif
      end
      M_CK: begin
        if (b == x_prev) exp_bright = m_shadow;
        else exp_err++;
        mode = M_IDLE;
      end
      default: ;
    endcase
  endtask

  task automatic mdl_ss_rise();
    if (mode == M_DROP) mode = M_IDLE;
    else if (mode != M_IDLE) begin exp_err++; mode = M_IDLE; end
  endtask

  // ---------------- per-cycle output checker ----------------
  int            dut_wr_cnt = 0;
  int            dut_err_cnt = 0;
  logic [AW-1:0] last_addr = '0;
  logic          wr_prev = 1'b0, err_prev = 1'b0;

  always @(negedge clk) begin
    if (!rstb) begin
      wr_prev  = 1'b0;
      err_prev = 1'b0;
    end else begin
      if (wr_en) begin
        wr_t e;
        chk("wr_en_single_cycle", 32'(wr_prev), 32'd0);
        chk("write_was_expected", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          chk("wr_addr", 32'(wr_addr), 32'(e.a));
          chk("wr_data", 32'(wr_data), 32'(e.d));
        end
        dut_wr_cnt++;
        last_addr = wr_addr;
      end
      if (frame_err) begin
        chk("frame_err_single_cycle", 32'(err_prev), 32'd0);
        dut_err_cnt++;
      end
      wr_prev  = wr_en;
      err_prev = frame_err;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic clks(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic open_frame();
    ss = 1'b0;
    clks(4);
  endtask

  task automatic send_byte(input logic [7:0] b);
    mdl_byte(b);
    rdata = b;
    done  = 1'b1;
    clks(4);
    done  = 1'b0;
    clks(4);
  endtask

  task automatic close_frame();
    ss = 1'b1;
    mdl_ss_rise();
    clks(10);
  endtask

  task automatic checkpoint(input string nm);
    @(negedge clk);
    chk({nm, "_err_count"}, 32'(dut_err_cnt), 32'(exp_err));
    chk({nm, "_brightness"}, 32'(brightness), 32'(exp_bright));
    chk({nm, "_busy"}, 32'(busy), 32'(mode != M_IDLE));
    chk({nm, "_writes_outstanding"}, 32'(exp_q.size()), 32'd0);
  endtask

  task automatic check_reset_values(input string nm);
    @(negedge clk);
    chk({nm, "_wr_en"}, 32'(wr_en), 32'd0);
    chk({nm, "_wr_addr"}, 32'(wr_addr), 32'd0);
    chk({nm, "_wr_data"}, 32'(wr_data), 32'd0);
    chk({nm, "_brightness"}, 32'(brightness), 32'hFF);
    chk({nm, "_frame_err"}, 32'(frame_err), 32'd0);
    chk({nm, "_busy"}, 32'(busy), 32'd0);
  endtask

  task automatic row_frame(input logic [7:0] row, input int mul);
    logic [7:0] x;
    open_frame();
    send_byte(8'h52);
    send_byte(row);
    x = 8'h52 ^ row;
    for (int i = 0; i < 192; i++) begin
      send_byte(8'((i * mul) & 255));
      x = x ^ 8'((i * mul) & 255);
    end
`ifdef SPI_CMD_CHECKSUM_EN
    send_byte(x);
`endif
    close_frame();
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int e0, w0;
    rstb = 1'b0; ss = 1'b1; done = 1'b0; rdata = 8'h00;
    clks(3);
    check_reset_values("reset");
    rstb = 1'b1;
    clks(3);

    // full row 3, data equals column index
    dut_wr_cnt = 0; e0 = dut_err_cnt;
    row_frame(8'h03, 1);
    checkpoint("row3");
    chk("row3_write_count", 32'(dut_wr_cnt), 32'd192);
    chk("row3_last_addr", 32'(last_addr), 32'h3BF);
    chk("row3_no_err", 32'(dut_err_cnt - e0), 32'd0);

    // brightness command
    dut_wr_cnt = 0; e0 = dut_err_cnt;
    open_frame();
    send_byte(8'h42);
    send_byte(8'h40);
`ifdef SPI_CMD_CHECKSUM_EN
    send_byte(8'h02);
`endif
    close_frame();
    checkpoint("bright");
    chk("bright_value", 32'(brightness), 32'h40);
    chk("bright_no_write", 32'(dut_wr_cnt), 32'd0);
    chk("bright_no_err", 32'(dut_err_cnt - e0), 32'd0);

    // unknown command: dropped until ss rises
    dut_wr_cnt = 0; e0 = dut_err_cnt;
    open_frame();
    send_byte(8'h77);
    for (int i = 0; i < 5; i++) send_byte(8'h52);
    checkpoint("unknown_open");
    chk("unknown_busy_in_drop", 32'(busy), 32'd1);
    close_frame();
    checkpoint("unknown_closed");
    chk("unknown_err_pulses", 32'(dut_err_cnt - e0), 32'd1);
    chk("unknown_no_write", 32'(dut_wr_cnt), 32'd0);

    // truncated row frame
    dut_wr_cnt = 0; e0 = dut_err_cnt;
    open_frame();
    send_byte(8'h52);
    send_byte(8'h01);
    for (int i = 0; i < 10; i++) send_byte(8'(8'hA0 + i));
    close_frame();
    checkpoint("trunc");
    chk("trunc_write_count", 32'(dut_wr_cnt), 32'd10);
    chk("trunc_err_pulses", 32'(dut_err_cnt - e0), 32'd1);
    chk("trunc_last_addr", 32'(last_addr), 32'h109);

    // NOP bytes, then out-of-range row address
    dut_wr_cnt = 0; e0 = dut_err_cnt;
    open_frame();
    send_byte(8'h00);
    send_byte(8'h00);
    send_byte(8'h52);
    send_byte(8'h20);
    send_byte(8'h11);
    close_frame();
    checkpoint("badrow");
    chk("badrow_err_pulses", 32'(dut_err_cnt - e0), 32'd1);
    chk("badrow_no_write", 32'(dut_wr_cnt), 32'd0);

`ifdef SPI_CMD_CHECKSUM_EN
    open_frame();
    send_byte(8'h42); send_byte(8'h10); send_byte(8'h52);
    close_frame();
    checkpoint("ck_good");
    chk("ck_good_bright", 32'(brightness), 32'h10);
    e0 = dut_err_cnt;
    open_frame();
    send_byte(8'h42); send_byte(8'h20); send_byte(8'h00);
    close_frame();
    checkpoint("ck_bad");
    chk("ck_bad_bright_held", 32'(brightness), 32'h10);
    chk("ck_bad_err", 32'(dut_err_cnt - e0), 32'd1);
`endif

    // reset mid-row after 50 bytes
    open_frame();
    send_byte(8'h52);
    send_byte(8'h05);
    for (int i = 0; i < 50; i++) send_byte(8'(i + 7));
    clks(4);
    rstb = 1'b0;
    ss   = 1'b1;
    exp_q.delete();
    mode = M_IDLE; exp_bright = 8'hFF; exp_err = 0; dut_err_cnt = 0;
    check_reset_values("midreset");
    rstb = 1'b1;
    w0 = dut_wr_cnt;
    clks(20);
    chk("midreset_no_more_writes", 32'(dut_wr_cnt - w0), 32'd0);
    dut_wr_cnt = 0;
    row_frame(8'h07, 3);
    checkpoint("after_reset_row");
    chk("after_reset_write_count", 32'(dut_wr_cnt), 32'd192);
    chk("after_reset_last_addr", 32'(last_addr), 32'h7BF);
    chk("after_reset_last_data", 32'(wr_data), 32'h3D);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/spi_cmd_parser.md
SPI_CMD_PARSER -- requirements
Module: spi_cmd_parser

Interface
REQ-001 SHALL have parameter ROW_BYTES, default 192, meaning payload bytes per display row (64 px x 3 colour bytes).
REQ-002 SHALL have parameter ROW_ADDR_W, default 5, meaning row-address width (32 rows).
REQ-003 SHALL have parameter COL_W, default 8, meaning column-address width; COL_W SHALL satisfy 2^COL_W >= ROW_BYTES.
REQ-004 SHALL have port clk, input, 1, meaning the system clock; it is the only clock in the block.
REQ-005 SHALL have port rstb, input, 1, meaning the asynchronous active-low reset.
REQ-006 SHALL have port ss, input, 1, meaning the SPI slave select (active low), arriving asynchronously to clk.
REQ-007 SHALL have port done, input, 1, meaning the SPI byte-complete flag from the SPI byte receiver, arriving asynchronously to clk.
REQ-008 SHALL have port rdata, input, 8, meaning the received byte, stable for at least one byte time after done rises.
REQ-009 SHALL have port wr_en, output, 1, meaning the framebuffer write strobe.
REQ-010 SHALL have port wr_addr, output, ROW_ADDR_W+COL_W, meaning the framebuffer address {row, col}.
REQ-011 SHALL have port wr_data, output, 8, meaning the framebuffer write data.
REQ-012 SHALL have port brightness, output, 8, meaning the global brightness register.
REQ-013 SHALL have port frame_err, output, 1, meaning a one-clk pulse on a protocol error.
REQ-014 SHALL have port busy, output, 1, meaning high whenever the state is not IDLE.

Function
REQ-015 SHALL pass ss and done through separate 2-flop synchronizers; a byte event is the rising edge of synchronized done (a third flop compares against the previous value).
REQ-016 SHALL capture rdata into a byte register on the byte-event clk; all decoding SHALL use this register.
REQ-017 SHALL implement states IDLE, ROW_ADDR, ROW_DATA, BRIGHT, CKSUM and DROP.
REQ-018 In IDLE, SHALL act on byte events as follows: 0x52 -> ROW_ADDR; 0x42 -> BRIGHT; 0x00 -> stay in IDLE; any other value -> frame_err pulse, then DROP.
REQ-019 In ROW_ADDR, SHALL latch byte[ROW_ADDR_W-1:0] as the row, clear col to 0, and go to ROW_DATA; if byte bits above ROW_ADDR_W are nonzero, SHALL pulse frame_err and go to DROP.
REQ-020 In ROW_DATA, each byte event SHALL assert wr_en for exactly one clk, one clk after the byte event, with wr_addr={row,col} and wr_data=byte; col SHALL then increment.
REQ-021 After the byte with col==ROW_BYTES-1 is written, SHALL go to CKSUM if checksum is compiled in, else to IDLE; col SHALL never wrap within a row.
REQ-022 In BRIGHT, the next byte event SHALL load brightness, then go to CKSUM or IDLE per REQ-021.
REQ-023 DROP SHALL ignore all byte events until synchronized ss rises, then go to IDLE.
REQ-024 A synchronized ss rising edge in any state other than IDLE or DROP SHALL return to IDLE and pulse frame_err (truncated frame); writes already issued are not undone.
REQ-025 If a byte event and an ss rising edge occur on the same clk, the byte SHALL be processed first and the ss edge handled on the next clk.
REQ-026 wr_en, wr_addr and wr_data SHALL be registered outputs; wr_addr and wr_data hold their last values when wr_en is low.

Reset
REQ-027 While rstb is low, SHALL force: state=IDLE, synchronizers to ss=1 and done=0, wr_en=0, wr_addr=0, wr_data=0, brightness=8'hFF, frame_err=0, busy=0, row=0, col=0.
REQ-028 Reset asserted mid-frame SHALL abort immediately; after release, the block SHALL wait in IDLE for a new command byte.

Configuration
REQ-029 SHALL honour macro SPI_CMD_CHECKSUM_EN: when defined, SHALL keep a running XOR over command and payload bytes; in CKSUM, the next byte SHALL be compared with it, and a mismatch SHALL pulse frame_err; brightness SHALL update only on a checksum match (held in a shadow register until then); state then goes to IDLE.
REQ-030 When SPI_CMD_CHECKSUM_EN is undefined, SHALL omit CKSUM and the XOR logic; frames SHALL end at the last payload byte.

Verification
REQ-031 Row frame 0x52,0x03, then 192 bytes 0x00..0xBF -> 192 single-clk wr_en pulses, wr_addr 0x300..0x3BF, wr_data equal to the column index, busy low afterwards.
REQ-032 Brightness frame 0x42,0x40 (checksum off) -> brightness=0x40, no wr_en, no frame_err.
REQ-033 Unknown command byte 0x77, then 5 bytes, then ss high -> one frame_err pulse, no writes, return to IDLE only after ss rises.
REQ-034 0x52,0x01, then 10 data bytes, then ss high -> 10 writes, one frame_err pulse, state IDLE.
REQ-035 With SPI_CMD_CHECKSUM_EN defined: frame 0x42,0x10,0x52 -> brightness=0x10; frame 0x42,0x10,0x00 -> frame_err, brightness unchanged.
REQ-036 rstb pulsed low mid-row after 50 bytes -> all outputs at reset values, no further wr_en; the next full row frame then writes correctly.
